// File: rtl/data_memory_ls_if.sv
// Load/store bus between the MEM stage and the byte-addressed data memory.
// The master drives the request, the slave returns the registered load result and status flags.
interface data_memory_ls_if #(
  parameter int n_addr = 10
);
  logic [n_addr-1:0] Addr;
  logic [31:0]       Wr_data;
  logic              MemWrite;
  logic              MemRead;
  logic [2:0]        Funct3;
  logic [31:0]       Rd_data;
  logic              Rd_valid;
  logic              Misalign;
  logic              Illegal_op;

  modport master (
    output Addr, Wr_data, MemWrite, MemRead, Funct3,
    input  Rd_data, Rd_valid, Misalign, Illegal_op
  );

  modport slave (
    input  Addr, Wr_data, MemWrite, MemRead, Funct3,
    output Rd_data, Rd_valid, Misalign, Illegal_op
  );
endinterface

// File: rtl/data_memory_ls.sv
// Byte-addressed RV32I data memory: LB/LH/LW/LBU/LHU and SB/SH/SW, one-cycle registered
// load result, misaligned/illegal requests flagged and blocked from touching memory.
module data_memory_ls #(
  parameter int n_addr = 10,
  parameter int n_bit  = 32
) (
  input logic             Clk,
  input logic             Rst,
  data_memory_ls_if.slave bus
);
  localparam int DEPTH = 2 ** (n_addr - 2);

  logic [n_bit-1:0] r_mem [DEPTH];
  logic [n_bit-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_misalign;
  logic             r_illegal;

  logic [n_addr-3:0] w_idx;
  logic [1:0]        w_lane;
  logic [2:0]        w_f3;
  logic              w_st_ok;
  logic              w_ld_ok;
  logic              w_req;
  logic              w_illegal;
  logic              w_misalign;
  logic              w_do_write;
  logic              w_do_read;
  logic [3:0]        w_be;
  logic [n_bit-1:0]  w_wdata;
  logic [n_bit-1:0]  w_cur;
  logic [n_bit-1:0]  w_merged;
  logic [n_bit-1:0]  w_shift;
  logic [n_bit-1:0]  w_load;

  assign w_idx  = bus.Addr[n_addr-1:2];
  assign w_lane = bus.Addr[1:0];
  assign w_f3   = bus.Funct3;

  assign w_st_ok = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010);
  assign w_ld_ok = w_st_ok || (w_f3 == 3'b100) || (w_f3 == 3'b101);
  assign w_req   = bus.MemWrite | bus.MemRead;

  // A combined request with a Funct3 legal for only one side is illegal as a whole.
  assign w_illegal  = (bus.MemWrite & ~w_st_ok) | (bus.MemRead & ~w_ld_ok);
  assign w_misalign = w_req & ~w_illegal &
                      (((w_f3[1:0] == 2'b01) & w_lane[0]) |
                       ((w_f3[1:0] == 2'b10) & (w_lane != 2'b00)));
  assign w_do_write = bus.MemWrite & ~w_illegal & ~w_misalign;
  assign w_do_read  = bus.MemRead  & ~w_illegal & ~w_misalign;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = '0;
    case (w_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{bus.Wr_data[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.Wr_data[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wdata = bus.Wr_data;
      end
      default: ;
    endcase
    if (!w_do_write) begin
      w_be = 4'b0000;
    end
  end

  assign w_cur = r_mem[w_idx];

  // Merged word is both the write-back value and the write-first read source.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_merged[gi*8 +: 8] = w_be[gi] ? w_wdata[gi*8 +: 8] : w_cur[gi*8 +: 8];
  end

  assign w_shift = w_merged >> {w_lane, 3'b000};

  always_comb begin
    case (w_f3)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_load = {24'd0, w_shift[7:0]};
      3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b101:  w_load = {16'd0, w_shift[15:0]};
      default: w_load = w_merged;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_misalign <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      if (w_do_write) begin
        r_mem[w_idx] <= w_merged;
      end
      r_rd_valid <= w_do_read;
      r_misalign <= w_misalign;
      r_illegal  <= w_illegal;
      if (w_do_read) begin
        r_rd_data <= w_load;
      end else if (w_illegal || w_misalign) begin
        r_rd_data <= '0;
      end
    end
  end

  assign bus.Rd_data    = r_rd_data;
  assign bus.Rd_valid   = r_rd_valid;
  assign bus.Misalign   = r_misalign;
  assign bus.Illegal_op = r_illegal;
endmodule

// File: doc/data_memory_ls.md
Name: data_memory_ls

Overview:
- Parametrised, byte-addressed successor to the word-only data memory. It sits in the MEM stage of the RISC-V 32-bit core.
- Supports all RV32I load/store widths, selected by funct3: LB/LH/LW/LBU/LHU and SB/SH/SW.
- Read data is registered with one cycle of latency and a valid strobe.
- Misaligned and illegal accesses are detected and flagged, and never corrupt memory.

Parameters:
- n_addr, 10, byte-address width; depth = 2**(n_addr-2) words (default 256 words = 1KB).
- n_bit, 32, data word width. Fixed at 32 for RV32; other values are unsupported.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Rst  input  1  asynchronous, active-low reset.
- Addr  input  n_addr  byte address of the access.
- Wr_data  input  32  store data; the relevant bytes are taken from the LSBs.
- MemWrite  input  1  store request for this cycle.
- MemRead  input  1  load request for this cycle.
- Funct3  input  3  access width and sign, RV32I encoding.
- Rd_data  output  32  extended load result, registered.
- Rd_valid  output  1  high for exactly the one cycle in which Rd_data holds a load result.
- Misalign  output  1  registered one-cycle pulse: the previous request was misaligned.
- Illegal_op  output  1  registered one-cycle pulse: the previous request used an unsupported Funct3.

Behaviour:
- Reset (Rst=0, asynchronous, at any time including mid-access):
  - Rd_data=0, Rd_valid=0, Misalign=0, Illegal_op=0.
  - All memory words cleared to 0.
  - Any store in flight in that cycle is discarded.
- Word index = Addr[n_addr-1:2]; byte lane = Addr[1:0]; little-endian (byte 0 = bits 7:0).
- Store, MemWrite=1, on posedge:
  - SB (000): writes byte lane Addr[1:0] with Wr_data[7:0].
  - SH (001): requires Addr[0]=0; writes lanes {Addr[1],0} and {Addr[1],1} with Wr_data[15:0].
  - SW (010): requires Addr[1:0]=0; writes the full word.
  - All other lanes in the word are unchanged.
- Load, MemRead=1, sampled on posedge; the result is on Rd_data with Rd_valid=1 during the following cycle:
  - LB (000) / LBU (100): selected byte, sign- or zero-extended to 32.
  - LH (001) / LHU (101): selected halfword, sign- or zero-extended; requires Addr[0]=0.
  - LW (010): full word; requires Addr[1:0]=0.
- Misaligned access (halfword with Addr[0]=1, word with Addr[1:0]!=0):
  - No memory write takes place.
  - Next cycle: Misalign=1, Rd_valid=0, Rd_data=0.
- Illegal Funct3:
  - Store with Funct3 not in {000,001,010}, or load with Funct3 in {011,110,111}.
  - No write takes place; next cycle Illegal_op=1, Rd_valid=0, Rd_data=0.
  - Illegal takes priority over misalign.
- MemWrite=1 and MemRead=1 in the same cycle:
  - Single access using the same Addr and Funct3.
  - Write-first: the store commits, and the next-cycle Rd_data returns the updated word, extended per Funct3 (store Funct3 decoding applies for the write, load decoding for the read).
  - If Funct3 is legal for one operation but not the other, Illegal_op=1 and neither operation takes effect.
- Idle cycle (MemRead=0, MemWrite=0, or a store only):
  - Rd_valid=0 and the flags are 0 next cycle.
  - Rd_data holds its last value.
- Back-to-back accesses run at full rate, one request per cycle, with no stall. A load immediately after a store to the same word returns the stored data.
- Address wrap: no wrap is needed; Addr spans exactly the depth.

Test Plan:
1. Reset, then SW 0x0002453E @0x24, then LW @0x24 -> Rd_data=0x0002453E, Rd_valid=1 for one cycle; Misalign=0.
2. SB 0x80 @0x25, then LB @0x25 -> 0xFFFFFF80. LBU @0x25 -> 0x00000080. LW @0x24 -> 0x0002803E.
3. SH 0xBEEF @0x26, then LH @0x26 -> 0xFFFFBEEF. LHU -> 0x0000BEEF. LW @0x24 -> 0xBEEF803E.
4. SW 0x12345678 @0x31 (misaligned) -> Misalign=1 next cycle; LW @0x30 returns 0x00000000. LH @0x27 -> Misalign=1, Rd_valid=0.
5. MemWrite=MemRead=1, SW 0x1453E @0x24 -> next-cycle Rd_data=0x0001453E. Load Funct3=011 -> Illegal_op=1, no write.
6. Rst driven low mid-stream, asynchronous to Clk, after several writes -> outputs 0 immediately. After release, LW @0x24 -> 0x00000000.
